register_file: RTL and testbench
================================

Name: register_file

Overview:
- Integer architectural register file: 32 x `DATA_WIDTH` entries.
- The consumer end of the writeback interface: it accepts the `rf_write_data_t` bundle driven by the writeback stage and commits it on the clock edge.
- Serves two combinational read ports to the decode stage, with same-cycle write-through bypass.
- Provides one registered debug read port for testbench and debug-module access.

Parameters:
- NUM_REGS, 32, number of architectural registers; must be a power of two.
- ADDR_W, 5, register address width; equals log2(NUM_REGS).
- RESET_CLEAR, 1, when 1 a reset zeroes all entries; when 0 reset clears only the debug output register.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rf_write_data_i  input  rf_write_data_t  writeback bundle: reg_write_en, rd_addr[ADDR_W-1:0], result_to_rf[`DATA_WIDTH-1:0].
- rs1_addr_i  input  ADDR_W  read port 1 address.
- rs1_data_o  output  `DATA_WIDTH  read port 1 data, combinational.
- rs2_addr_i  input  ADDR_W  read port 2 address.
- rs2_data_o  output  `DATA_WIDTH  read port 2 data, combinational.
- dbg_rd_en_i  input  1  debug read request.
- dbg_addr_i  input  ADDR_W  debug read address.
- dbg_data_o  output  `DATA_WIDTH  debug read data, registered.
- dbg_valid_o  output  1  dbg_data_o holds the result of a request.

Behaviour:
- Reset (rst=1 at a clock edge):
  - If RESET_CLEAR=1, all entries become 0.
  - dbg_data_o becomes 0 and dbg_valid_o becomes 0.
  - A write presented in the same cycle as reset is discarded; reset wins.
  - rs1_data_o and rs2_data_o are combinational and reflect the post-reset array in the following cycle.
- Write:
  - On a rising edge with rst=0, reg_write_en=1 and rd_addr!=0, entry[rd_addr] <= result_to_rf.
  - A write with rd_addr=0 is silently dropped; entry 0 never holds a non-zero value.
  - The write commits at the edge; no other latency.
- Read ports 1 and 2, evaluated combinationally and independently:
  - addr==0 -> output 0, unconditionally, including during a bypass.
  - Otherwise, if reg_write_en=1 and rd_addr==addr -> output result_to_rf (write-through bypass). This removes the WB->ID hazard within one cycle.
  - Otherwise -> output entry[addr].
  - Both ports may read the same address; both see identical data.
- Debug port:
  - 1-cycle latency. On an edge with dbg_rd_en_i=1, dbg_data_o <= the value the same bypass rules yield for dbg_addr_i, and dbg_valid_o <= 1.
  - On an edge with dbg_rd_en_i=0, dbg_valid_o <= 0 and dbg_data_o holds its previous value.
  - Back-to-back requests give one result per cycle.
- Simultaneous events:
  - A write and a debug read to the same address in the same cycle return the new write data.
  - A debug request in a reset cycle is dropped: dbg_valid_o=0 in the next cycle.
- There is no X propagation from the array; every entry is defined after the first reset when RESET_CLEAR=1.
- Array storage is a flop array with one write port. No byte enables.

Test Plan:
- Reset clear:
  - Write 0xDEADBEEF to x5, then assert rst for 1 cycle.
  - Read rs1=x5 -> 0.
  - dbg_valid_o=0 after reset.
- Write/read, x0 hardwire:
  - Write 0x12345678 to x0 -> rs1=x0 reads 0, both before and after the edge.
  - Write 0xCAFEF00D to x31 -> rs2=x31 reads 0xCAFEF00D in the following cycle.
- Bypass:
  - x7 holds 0x1; drive write x7=0xAAAA5555 with rs1=rs2=x7 in the same cycle.
  - Both outputs = 0xAAAA5555 combinationally, before the edge.
  - Bypass with rd=x0 still yields 0.
- Debug latency:
  - Write x3=0x33, x4=0x44.
  - Issue dbg reads x3 then x4 on consecutive cycles.
  - dbg_data_o = 0x33 then 0x44, each with dbg_valid_o=1, one cycle after each request.
  - dbg_valid_o drops to 0 the cycle after dbg_rd_en_i deasserts.
- Reset wins over write:
  - Assert rst together with write x9=0xFFFF.
  - Next cycle: x9 reads 0 (RESET_CLEAR=1).
- Sweep:
  - Write x1..x31 with value (i*0x01010101).
  - Read all 31 via rs1, rs2 and the debug port.
  - All match; x0 reads 0.

Source files
------------

// File: rtl/register_file.sv
// Purpose: 32-entry integer architectural register file; two bypassed combinational read ports, one registered debug port.
// Latency: writes commit at the clock edge; rs1/rs2 reads are combinational; debug reads return one cycle after the request.
// Backpressure: none; every write and every debug request is accepted on the cycle it is presented.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package register_file_pkg;

    // Address width of the writeback bundle; the register file's ADDR_W must not exceed it.
    localparam int RF_ADDR_W = 5;

    // Writeback stage -> register file bundle.
    typedef struct packed {
        logic                   reg_write_en;
        logic [RF_ADDR_W-1:0]   rd_addr;
        logic [`DATA_WIDTH-1:0] result_to_rf;
    } rf_write_data_t;

endpackage

module register_file
    import register_file_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter bit RESET_CLEAR = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  rf_write_data_t         rf_write_data_i,
    input  logic [ADDR_W-1:0]      rs1_addr_i,
    output logic [`DATA_WIDTH-1:0] rs1_data_o,
    input  logic [ADDR_W-1:0]      rs2_addr_i,
    output logic [`DATA_WIDTH-1:0] rs2_data_o,
    input  logic                   dbg_rd_en_i,
    input  logic [ADDR_W-1:0]      dbg_addr_i,
    output logic [`DATA_WIDTH-1:0] dbg_data_o,
    output logic                   dbg_valid_o
);

    localparam int DW = `DATA_WIDTH;

    logic [DW-1:0]     regs_q [NUM_REGS];
    logic [DW-1:0]     regs_d [NUM_REGS];
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_hit;
    logic [DW-1:0]     dbg_data_q;
    logic [DW-1:0]     dbg_data_d;
    logic              dbg_valid_q;
    logic              dbg_valid_d;

    assign wr_addr = rf_write_data_i.rd_addr[ADDR_W-1:0];
    assign wr_hit  = rf_write_data_i.reg_write_en && (wr_addr != '0);

    // Next-state array: the current contents with this cycle's write folded in.
    // It doubles as the write-through view for every read port, so all ports see
    // identical bypass behaviour. Entry 0 is forced to zero both as storage and as
    // a read result, which also hides a bypass aimed at x0.
    always_comb begin
        regs_d[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_hit) begin
            regs_d[wr_addr] = rf_write_data_i.result_to_rf;
        end
        regs_d[0] = '0;
    end

    // Decode-stage read ports, purely combinational through the bypassed view.
    always_comb begin
        rs1_data_o = regs_d[rs1_addr_i];
        rs2_data_o = regs_d[rs2_addr_i];
    end

    // Debug port next state: capture the bypassed value on request, otherwise hold data and drop valid.
    always_comb begin
        dbg_valid_d = dbg_rd_en_i;
        dbg_data_d  = dbg_data_q;
        if (dbg_rd_en_i) begin
            dbg_data_d = regs_d[dbg_addr_i];
        end
    end

    // State update; reset discards any same-cycle write and debug request.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (RESET_CLEAR) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    regs_q[i] <= '0;
                end
            end
            dbg_data_q  <= '0;
            dbg_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            dbg_data_q  <= dbg_data_d;
            dbg_valid_q <= dbg_valid_d;
        end
    end

    assign dbg_data_o  = dbg_data_q;
    assign dbg_valid_o = dbg_valid_q;

endmodule

// File: tb/tb_register_file.sv
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_register_file;
    import register_file_pkg::*;

    localparam int DW = `DATA_WIDTH;

    logic           clk = 1'b0;
    logic           rst;
    rf_write_data_t wb;
    logic [4:0]     rs1_a, rs2_a, dbg_a;
    logic [DW-1:0]  rs1_d, rs2_d, dbg_d;
    logic           dbg_en, dbg_v;

    always #5 clk = ~clk;

    register_file #(
        .NUM_REGS   (32),
        .ADDR_W     (5),
        .RESET_CLEAR(1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rf_write_data_i(wb),
        .rs1_addr_i     (rs1_a),
        .rs1_data_o     (rs1_d),
        .rs2_addr_i     (rs2_a),
        .rs2_data_o     (rs2_d),
        .dbg_rd_en_i    (dbg_en),
        .dbg_addr_i     (dbg_a),
        .dbg_data_o     (dbg_d),
        .dbg_valid_o    (dbg_v)
    );

    typedef struct {
        logic          vld;
        logic [DW-1:0] dat;
    } dbg_exp_t;

    int            n_chk  = 0;
    int            n_fail = 0;
    dbg_exp_t      sb_q[$];
    logic [DW-1:0] mem [32];
    logic [DW-1:0] dbg_hold;
    bit            model_ok = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference read: x0 is zero, a same-cycle write to the address wins, else stored value.
    function automatic logic [DW-1:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return '0;
        if (wb.reg_write_en && wb.rd_addr == a) return wb.result_to_rf;
        return mem[a];
    endfunction

    // One clock cycle: drive, check combinational reads mid-cycle, then at the edge
    // record the expected debug output and update the model.
    task automatic step(input bit r, input bit we, input logic [4:0] wa, input logic [DW-1:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input bit de, input logic [4:0] da, input string tag);
        dbg_exp_t e;
        rst                = r;
        wb.reg_write_en    = we;
        wb.rd_addr         = wa;
        wb.result_to_rf    = wd;
        rs1_a              = a1;
        rs2_a              = a2;
        dbg_en             = de;
        dbg_a              = da;
        @(negedge clk);
        if (model_ok) begin
            check({tag, "/rs1"}, rs1_d, model_read(a1));
            check({tag, "/rs2"}, rs2_d, model_read(a2));
        end
        @(posedge clk);
        if (r) begin
            e.vld    = 1'b0;
            e.dat    = '0;
            dbg_hold = '0;
            for (int i = 0; i < 32; i++) mem[i] = '0;
            model_ok = 1'b1;
        end else begin
            if (de) begin
                e.vld    = 1'b1;
                e.dat    = model_read(da);
                dbg_hold = e.dat;
            end else begin
                e.vld = 1'b0;
                e.dat = dbg_hold;
            end
            if (we && wa != 5'd0) mem[wa] = wd;
        end
        sb_q.push_back(e);
        #1;
    endtask

    // Monitor: every cycle after the first recorded edge the debug port presents a result to compare.
    initial begin : monitor
        dbg_exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("dbg_valid", {{(DW-1){1'b0}}, dbg_v}, {{(DW-1){1'b0}}, e.vld});
                check("dbg_data", dbg_d, e.dat);
            end
        end
    end

    initial begin : stim
        logic [4:0]    wa, a1, a2, da;
        logic [DW-1:0] wd;
        bit            we, de, r;

        // Initial reset.
        step(1, 0, 0, '0, 0, 0, 0, 0, "rst0");
        step(1, 0, 0, '0, 0, 0, 0, 0, "rst1");

        // Reset clears x5; debug request in the reset cycle is dropped.
        step(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, "wr_x5");
        step(1, 0, 0, '0, 5, 5, 1, 5, "rst_x5");
        step(0, 0, 0, '0, 5, 5, 0, 0, "rd_x5");

        // x0 hardwire and x31 write.
        step(0, 1, 0, 32'h12345678, 0, 0, 0, 0, "wr_x0");
        step(0, 0, 0, '0, 0, 0, 1, 0, "rd_x0");
        step(0, 1, 31, 32'hCAFEF00D, 0, 31, 0, 0, "wr_x31");
        step(0, 0, 0, '0, 0, 31, 0, 0, "rd_x31");

        // Bypass.
        step(0, 1, 7, 32'h1, 0, 0, 0, 0, "wr_x7");
        step(0, 1, 7, 32'hAAAA5555, 7, 7, 0, 0, "byp_x7");
        step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, "byp_x0");

        // Debug latency, back-to-back, then deassert.
        step(0, 1, 3, 32'h33, 0, 0, 0, 0, "wr_x3");
        step(0, 1, 4, 32'h44, 0, 0, 0, 0, "wr_x4");
        step(0, 0, 0, '0, 3, 4, 1, 3, "dbg_x3");
        step(0, 0, 0, '0, 4, 3, 1, 4, "dbg_x4");
        step(0, 0, 0, '0, 0, 0, 0, 0, "dbg_off");

        // Write and debug read of the same address in one cycle.
        step(0, 1, 10, 32'h10101010, 10, 10, 1, 10, "wr_dbg_x10");

        // Reset wins over a same-cycle write.
        step(1, 1, 9, 32'hFFFF, 9, 0, 0, 0, "rst_wr_x9");
        step(0, 0, 0, '0, 9, 9, 1, 9, "rd_x9");

        // Sweep.
        for (int i = 1; i < 32; i++) begin
            step(0, 1, 5'(i), 32'(i) * 32'h01010101, 0, 0, 0, 0, "sweep_wr");
        end
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, '0, 5'(i), 5'(31 - i), 1, 5'(i), "sweep_rd");
        end

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 63) == 0);
            we = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = DW'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            de = ($urandom_range(0, 1) == 1);
            da = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            step(r, we, wa, wd, a1, a2, de, da, "rand");
        end

        step(0, 0, 0, '0, 0, 0, 0, 0, "idle");
        @(negedge clk);
        #1;
        check("sb_drained", DW'(sb_q.size()), '0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin : watchdog
        #500000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $fatal(1, "timeout");
    end

endmodule
